// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: shares one single-port memory bus between a core's
// instruction port (I) and data port (D). Round-robin arbitration, one
// transaction in flight at a time, combinational response routing to the
// granted port. A watchdog aborts a transaction if the memory never answers.

module memory_bus_arbiter #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  reset,
    // instruction port
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    output logic [DATA_WIDTH-1:0] i_read_data,
    output logic                  i_response,
    // data port
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0] d_write_data,
    output logic [DATA_WIDTH-1:0] d_read_data,
    output logic                  d_response,
    // memory side
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_response,
    // status
    output logic [1:0]            grant,
    output logic                  bus_error
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Watchdog compare value; a zero TIMEOUT_CYCLES disables the watchdog.
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_EN ? 16'(TIMEOUT_CYCLES - 32'd1) : 16'd0;

    state_t                r_state;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_write_data;
    logic [1:0]            r_grant;
    logic                  r_last_grant_d;   // 1: D owned the bus last, so I wins the next tie
    logic                  r_bus_error;
    logic [15:0]           r_count;

    state_t                w_state_nxt;
    logic                  w_mem_read_nxt;
    logic                  w_mem_write_nxt;
    logic [ADDR_WIDTH-1:0] w_mem_address_nxt;
    logic [DATA_WIDTH-1:0] w_mem_write_data_nxt;
    logic [1:0]            w_grant_nxt;
    logic                  w_last_grant_d_nxt;
    logic                  w_bus_error_nxt;
    logic [15:0]           w_count_nxt;

    logic                  w_req_i;
    logic                  w_req_d;
    logic                  w_pick_d;
    logic                  w_timeout;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_req_i  = i_read | i_write;
    assign w_req_d  = d_read | d_write;
    // D wins only when I is not requesting or I owned the bus last.
    assign w_pick_d = w_req_d & (~w_req_i | ~r_last_grant_d);

    // mem_response takes priority over the watchdog in the same cycle.
    assign w_timeout = (r_state == ST_BUSY) && !mem_response && TIMEOUT_EN
                       && (r_count == TIMEOUT_LAST);
    assign w_done    = (r_state == ST_BUSY) && (mem_response || w_timeout);
    assign w_rdata   = w_timeout ? TIMEOUT_DATA : mem_read_data;

    assign i_response     = w_done & r_grant[0];
    assign d_response     = w_done & r_grant[1];
    assign i_read_data    = w_rdata;
    assign d_read_data    = w_rdata;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_write_data;
    assign grant          = r_grant;
    assign bus_error      = r_bus_error;

    // Next-state logic: arbitration in IDLE, completion/watchdog in BUSY.
    always_comb begin
        w_state_nxt          = r_state;
        w_mem_read_nxt       = r_mem_read;
        w_mem_write_nxt      = r_mem_write;
        w_mem_address_nxt    = r_mem_address;
        w_mem_write_data_nxt = r_mem_write_data;
        w_grant_nxt          = r_grant;
        w_last_grant_d_nxt   = r_last_grant_d;
        w_bus_error_nxt      = r_bus_error;
        w_count_nxt          = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_req_i || w_req_d) begin
                    // Read and write together is treated as a write.
                    if (w_pick_d) begin
                        w_mem_write_nxt      = d_write;
                        w_mem_read_nxt       = d_read & ~d_write;
                        w_mem_address_nxt    = d_address;
                        w_mem_write_data_nxt = d_write_data;
                        w_grant_nxt          = 2'b10;
                        w_last_grant_d_nxt   = 1'b1;
                    end else begin
                        w_mem_write_nxt      = i_write;
                        w_mem_read_nxt       = i_read & ~i_write;
                        w_mem_address_nxt    = i_address;
                        w_mem_write_data_nxt = i_write_data;
                        w_grant_nxt          = 2'b01;
                        w_last_grant_d_nxt   = 1'b0;
                    end
                    w_count_nxt = 16'd0;
                    w_state_nxt = ST_BUSY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (w_done) begin
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_grant_nxt     = 2'b00;
                    w_state_nxt     = ST_IDLE;
                    if (w_timeout) begin
                        w_bus_error_nxt = 1'b1;
                    end else begin
                        w_bus_error_nxt = r_bus_error;
                    end
                end else begin
                    w_count_nxt = r_count + 16'd1;
                end
            end
            default: begin
                w_mem_read_nxt  = 1'b0;
                w_mem_write_nxt = 1'b0;
                w_grant_nxt     = 2'b00;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

    // State and bus registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state          <= ST_IDLE;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_address    <= {ADDR_WIDTH{1'b0}};
            r_mem_write_data <= {DATA_WIDTH{1'b0}};
            r_grant          <= 2'b00;
            r_last_grant_d   <= 1'b1;
            r_bus_error      <= 1'b0;
            r_count          <= 16'd0;
        end else begin
            r_state          <= w_state_nxt;
            r_mem_read       <= w_mem_read_nxt;
            r_mem_write      <= w_mem_write_nxt;
            r_mem_address    <= w_mem_address_nxt;
            r_mem_write_data <= w_mem_write_data_nxt;
            r_grant          <= w_grant_nxt;
            r_last_grant_d   <= w_last_grant_d_nxt;
            r_bus_error      <= w_bus_error_nxt;
            r_count          <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Testbench for memory_bus_arbiter: two requester agents push expected
// transactions into per-port queues; a monitor running on the falling edge
// predicts grants, strobes, responses and bus_error from the arbitration rules
// and pops the queues as responses appear.

module tb_memory_bus_arbiter;

    localparam int TO = 8;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_read, i_write, d_read, d_write;
    logic [31:0] i_address, i_write_data, d_address, d_write_data;
    logic [31:0] i_read_data, d_read_data;
    logic        i_response, d_response;
    logic        mem_read, mem_write, mem_response;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic [1:0]  grant;
    logic        bus_error;

    int   n_checks = 0;
    int   n_err    = 0;
    txn_t q_i[$];
    txn_t q_d[$];
    bit   silent     = 1'b0;
    bit   force_resp = 1'b0;

    memory_bus_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(32'hDEADBEEF)
    ) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_write_data(i_write_data),
        .i_read_data(i_read_data), .i_response(i_response),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_write_data(d_write_data),
        .d_read_data(d_read_data), .d_response(d_response),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_response(mem_response),
        .grant(grant), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_data(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: answers 0..3 cycles after the strobe unless silent.
    initial begin : responder
        bit armed;
        bit done;
        int wcnt;
        armed = 1'b0; done = 1'b0; wcnt = 0;
        mem_response  = 1'b0;
        mem_read_data = 32'h0;
        forever begin
            @(posedge clk); #1;
            mem_response  = 1'b0;
            mem_read_data = $urandom;
            if (force_resp) begin
                mem_response = 1'b1;
            end else if (!(mem_read || mem_write)) begin
                armed = 1'b0; done = 1'b0;
            end else if (!done) begin
                if (!armed) begin
                    armed = 1'b1;
                    wcnt  = $urandom_range(0, 3);
                end else if (wcnt > 0) begin
                    wcnt--;
                end
                if (wcnt == 0 && !silent) begin
                    mem_response  = 1'b1;
                    mem_read_data = ref_data(mem_address);
                    done          = 1'b1;
                end
            end
        end
    end

    // Monitor / scoreboard with a rule-level model of the arbiter.
    logic p_req_i = 1'b0, p_req_d = 1'b0, p_rst_low = 1'b0, mon_on = 1'b0;
    logic [1:0] p_gnt = 2'b00;
    bit   m_last_d = 1'b1;
    bit   m_err    = 1'b0;
    bit   cur_d    = 1'b0;
    int   busy     = 0;
    txn_t cur;
    bit   exp_to, exp_r;
    logic [31:0] rdat;

    initial begin : monitor
        cur = '0;
        forever begin
            @(negedge clk);
            if (p_rst_low) begin
                mon_on = 1'b1;
                chk("rst_grant", {30'd0, grant}, 32'd0);
                chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
                chk("rst_addr", mem_address, 32'd0);
                chk("rst_wdata", mem_write_data, 32'd0);
                chk("rst_bus_error", {31'd0, bus_error}, 32'd0);
                chk("rst_responses", {30'd0, i_response, d_response}, 32'd0);
                q_i.delete(); q_d.delete();
                m_last_d = 1'b1; m_err = 1'b0; busy = 0;
            end else if (mon_on) begin
                chk("bus_error", {31'd0, bus_error}, {31'd0, m_err});
                if (grant == 2'b00) begin
                    chk("idle_responses", {30'd0, i_response, d_response}, 32'd0);
                    chk("idle_strobes", {30'd0, mem_read, mem_write}, 32'd0);
                    if (p_gnt == 2'b00 && (p_req_i || p_req_d)) begin
                        n_checks++; n_err++;
                        $display("FAIL missing_grant: got 00 expected a grant at %0t", $time);
                    end
                end else begin
                    if (p_gnt == 2'b00) begin
                        // New grant: round-robin decision on last idle cycle's requests.
                        cur_d = p_req_d && (!p_req_i || !m_last_d);
                        n_checks++;
                        if (!(p_req_i || p_req_d)) begin
                            n_err++;
                            $display("FAIL spurious_grant: got %b expected 00 at %0t", grant, $time);
                        end
                        m_last_d = cur_d;
                        busy = 0;
                        if (cur_d ? (q_d.size() == 0) : (q_i.size() == 0)) begin
                            n_checks++; n_err++;
                            $display("FAIL sb_empty: got empty queue expected a txn at %0t", $time);
                            cur = '0;
                        end else begin
                            cur = cur_d ? q_d[0] : q_i[0];
                        end
                    end
                    chk("grant", {30'd0, grant}, cur_d ? 32'd2 : 32'd1);
                    chk("mem_read", {31'd0, mem_read}, {31'd0, cur.rd & ~cur.wr});
                    chk("mem_write", {31'd0, mem_write}, {31'd0, cur.wr});
                    chk("mem_address", mem_address, cur.addr);
                    if (cur.wr) chk("mem_write_data", mem_write_data, cur.wdata);
                    exp_to = !mem_response && (busy == TO - 1);
                    exp_r  = mem_response || exp_to;
                    chk("i_response", {31'd0, i_response}, {31'd0, exp_r && !cur_d});
                    chk("d_response", {31'd0, d_response}, {31'd0, exp_r && cur_d});
                    if (exp_r) begin
                        rdat = cur_d ? d_read_data : i_read_data;
                        if (exp_to) begin
                            chk("timeout_data", rdat, 32'hDEADBEEF);
                            m_err = 1'b1;
                        end else if (cur.rd && !cur.wr) begin
                            chk("read_data", rdat, ref_data(cur.addr));
                        end
                        if (cur_d && q_d.size() > 0) void'(q_d.pop_front());
                        if (!cur_d && q_i.size() > 0) void'(q_i.pop_front());
                    end
                    busy++;
                end
            end
            p_req_i   = i_read | i_write;
            p_req_d   = d_read | d_write;
            p_gnt     = grant;
            p_rst_low = !reset;
        end
    end

    // One requester transaction; entered and left just after a rising edge.
    task automatic do_txn(input bit port_d, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        int   n;
        t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata;
        if (port_d) begin
            q_d.push_back(t);
            d_read = rd; d_write = wr; d_address = addr; d_write_data = wdata;
        end else begin
            q_i.push_back(t);
            i_read = rd; i_write = wr; i_address = addr; i_write_data = wdata;
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (port_d ? d_response : i_response) break;
            n++;
            if (n > 60) begin
                n_checks++; n_err++;
                $display("FAIL resp_wait: got no response expected one within 60 cycles port_d=%0d", port_d);
                break;
            end
        end
        @(posedge clk); #1;
        if (port_d) begin d_read = 1'b0; d_write = 1'b0; end
        else begin i_read = 1'b0; i_write = 1'b0; end
    endtask

    task automatic rand_txn(input bit port_d);
        int op;
        op = $urandom_range(0, 2);
        do_txn(port_d, op != 1, op != 0, $urandom, $urandom);
    endtask

    task automatic gap(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic agent(input bit port_d, input int count, input bit random_gap);
        for (int k = 0; k < count; k++) begin
            if (random_gap) gap($urandom_range(0, 3));
            rand_txn(port_d);
        end
    endtask

    initial begin : main
        int n;
        reset = 1'b0;
        i_read = 1'b0; i_write = 1'b0; i_address = 32'h0; i_write_data = 32'h0;
        d_read = 1'b0; d_write = 1'b0; d_address = 32'h0; d_write_data = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        gap(2);

        // Simultaneous requests right after reset: I wins, then D's write.
        fork
            do_txn(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
            do_txn(1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D);
        join
        gap(1);
        // Single read.
        do_txn(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        gap(1);
        // Read and write together on port I is a write.
        do_txn(1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h1357_9BDF);
        gap(2);
        // Continuous contention: three each, no gaps.
        fork
            agent(1'b0, 3, 1'b0);
            agent(1'b1, 3, 1'b0);
        join
        gap(2);
        // Random traffic on both ports.
        fork
            agent(1'b0, 15, 1'b1);
            agent(1'b1, 15, 1'b1);
        join
        gap(2);
        // Timeout on port D, then good traffic with bus_error held.
        silent = 1'b1;
        do_txn(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
        silent = 1'b0;
        gap(1);
        do_txn(1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
        do_txn(1'b1, 1'b0, 1'b1, 32'h0000_0600, 32'hA5A5_5A5A);
        gap(2);
        chk("sb_drained", q_i.size() + q_d.size(), 32'd0);
        chk("bus_error_sticky", {31'd0, bus_error}, 32'd1);

        // Reset while BUSY, then a late memory response.
        silent = 1'b1;
        q_i.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0700, wdata: 32'h0});
        i_read = 1'b1; i_address = 32'h0000_0700;
        n = 0;
        while (!mem_read && n < 20) begin gap(1); n++; end
        chk("strobe_before_reset", {31'd0, mem_read}, 32'd1);
        gap(1);
        reset = 1'b0; i_read = 1'b0;
        gap(1);
        reset = 1'b1; force_resp = 1'b1;
        gap(1);
        force_resp = 1'b0; silent = 1'b0;
        gap(1);
        chk("post_reset_grant", {30'd0, grant}, 32'd0);
        chk("post_reset_bus_error", {31'd0, bus_error}, 32'd0);
        // Bus still works after reset; I wins again.
        do_txn(1'b0, 1'b1, 1'b0, 32'h0000_0800, 32'h0);
        gap(3);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "timeout");
    end

endmodule
